// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_sequencer
//  Purpose  : Schedules NUM_PATTERNS row-pattern generators. Shows one source
//             for a dwell period, emits BLANK_CYCLES all-zero rows, then
//             advances to the next source (wrapping to 0). Rows reach the
//             display driver through a single registered valid/ready slot.
//  Ports    : clk_in, reset_in          clock / synchronous active-high reset
//             pattern_rows_in           one row per generator
//             colour_in                 base colour {b,g,r}
//             next_in, hold_in          advance pulse / dwell freeze level
//             row_out, row_valid_out,   output slot towards the row driver
//             row_ready_in
//             colour_out                colour to every generator
//             pattern_sel_out           index currently shown
//             pattern_restart_out       one-hot restart pulse per generator
//  Config   : COLOUR_CYCLE_EN  defined   -> colour_out steps 001..111 on
//                                           every wrap of pattern_sel_out
//                              undefined -> colour_out = colour_in, 1 cycle late
//  Revision : 1.0  initial release
// ============================================================================
module pattern_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int DWELL_TIME   = 50_000_000,
    parameter int BLANK_CYCLES = 16,
    parameter int SIMULATION   = 0,
    parameter int ROW_W        = 24,
    parameter int SEL_W        = $clog2(NUM_PATTERNS)
) (
    input  logic                                clk_in,
    input  logic                                reset_in,
    input  logic [NUM_PATTERNS-1:0][ROW_W-1:0]  pattern_rows_in,
    input  logic [2:0]                          colour_in,
    input  logic                                next_in,
    input  logic                                hold_in,
    output logic [ROW_W-1:0]                    row_out,
    output logic                                row_valid_out,
    input  logic                                row_ready_in,
    output logic [2:0]                          colour_out,
    output logic [SEL_W-1:0]                    pattern_sel_out,
    output logic [NUM_PATTERNS-1:0]             pattern_restart_out
);

    localparam int c_DWELL_LIMIT = (SIMULATION != 0) ? 64 : DWELL_TIME;
    localparam int c_DWELL_W     = $clog2(c_DWELL_LIMIT + 1);
    localparam int c_BLANK_W     = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_DWELL_W-1:0]     r_dwell_cnt;
    logic [c_BLANK_W-1:0]     r_blank_cnt;
    logic [SEL_W-1:0]         r_sel;
    logic [SEL_W-1:0]         w_sel_next;
    logic [NUM_PATTERNS-1:0]  r_restart;
    logic [ROW_W-1:0]         r_row;
    logic                     r_valid;
    logic [2:0]               r_colour;
    logic                     w_dwell_expire;
    logic                     w_blank_done;
    logic                     w_wrap;
    logic                     w_load;

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next   = r_state;
        // A held counter never expires; only an unheld cycle at limit-1 does.
        w_dwell_expire = !hold_in && (r_dwell_cnt == c_DWELL_W'(c_DWELL_LIMIT - 1));
        w_blank_done   = (r_blank_cnt == c_BLANK_W'(BLANK_CYCLES - 1));
        w_wrap         = (r_sel == SEL_W'(NUM_PATTERNS - 1));
        w_sel_next     = w_wrap ? '0 : r_sel + 1'b1;
        // The slot accepts new data only when empty or being drained.
        w_load         = (r_state != S_IDLE) && (!r_valid || row_ready_in);
        case (r_state)
            S_IDLE:  w_state_next = S_RUN;
            S_RUN:   if (next_in || w_dwell_expire) w_state_next = S_BLANK;
            S_BLANK: if (w_blank_done) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_in) begin
        if (reset_in) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // ---------------- counters, selection, restart ----------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_dwell_cnt <= '0;
            r_blank_cnt <= '0;
            r_sel       <= '0;
            r_restart   <= '0;
        end else begin
            r_restart <= '0;
            case (r_state)
                S_IDLE: begin
                    r_restart   <= NUM_PATTERNS'(1);
                    r_dwell_cnt <= '0;
                end
                S_RUN: begin
                    if (w_state_next == S_BLANK)
                        r_blank_cnt <= '0;
                    else if (!hold_in)
                        r_dwell_cnt <= r_dwell_cnt + 1'b1;
                end
                S_BLANK: begin
                    if (w_blank_done) begin
                        r_sel       <= w_sel_next;
                        r_restart   <= NUM_PATTERNS'(1) << w_sel_next;
                        r_dwell_cnt <= '0;
                    end else begin
                        r_blank_cnt <= r_blank_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- output slot ----------------
    // Data is chosen from the state at load time, so a row stalled in the
    // slot keeps its old-pattern contents until the driver takes it.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_row   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_row   <= (r_state == S_RUN) ? pattern_rows_in[r_sel] : '0;
            r_valid <= 1'b1;
        end
    end

    // ---------------- colour ----------------
`ifdef COLOUR_CYCLE_EN
    logic w_unused_colour;
    assign w_unused_colour = ^colour_in;

    always_ff @(posedge clk_in) begin
        if (reset_in)
            r_colour <= 3'b001;
        else if (r_state == S_BLANK && w_blank_done && w_wrap)
            r_colour <= (r_colour == 3'b111) ? 3'b001 : r_colour + 3'd1;
    end
`else
    always_ff @(posedge clk_in) begin
        r_colour <= colour_in;
    end
`endif

    assign row_out             = r_row;
    assign row_valid_out       = r_valid;
    assign colour_out          = r_colour;
    assign pattern_sel_out     = r_sel;
    assign pattern_restart_out = r_restart;

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_sequencer
//  Purpose  : Self-checking bench for pattern_sequencer (SIMULATION=1,
//             4 patterns, 16 blank cycles). A cycle-level reference model
//             built from phase lengths is compared every cycle; a directed
//             prologue pins key instants with literal values, then a long
//             randomized run exercises stalls, holds, advances and resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pattern_sequencer;

    localparam int NP    = 4;
    localparam int RW    = 24;
    localparam int DWELL = 64;
    localparam int BLANK = 16;

    localparam logic [RW-1:0] ROW0 = 24'h110000;
    localparam logic [RW-1:0] ROW1 = 24'h002200;
    localparam logic [RW-1:0] ROW2 = 24'h000033;
    localparam logic [RW-1:0] ROW3 = 24'h444444;
    localparam logic [RW-1:0] ALT3 = 24'hABCDEF;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NP-1:0][RW-1:0]   rows;
    logic [2:0]              colour;
    logic                    next_p;
    logic                    hold;
    logic                    ready;
    logic [RW-1:0]           row_out;
    logic                    row_valid;
    logic [2:0]              colour_out;
    logic [1:0]              sel;
    logic [NP-1:0]           restart;

    always #5 clk = ~clk;

    pattern_sequencer #(
        .NUM_PATTERNS (NP),
        .DWELL_TIME   (50_000_000),
        .BLANK_CYCLES (BLANK),
        .SIMULATION   (1),
        .ROW_W        (RW)
    ) u_dut (
        .clk_in              (clk),
        .reset_in            (reset),
        .pattern_rows_in     (rows),
        .colour_in           (colour),
        .next_in             (next_p),
        .hold_in             (hold),
        .row_out             (row_out),
        .row_valid_out       (row_valid),
        .row_ready_in        (ready),
        .colour_out          (colour_out),
        .pattern_sel_out     (sel),
        .pattern_restart_out (restart)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase 0 = idle, 1 = showing a pattern, 2 = blanking. Progress in a
    // phase is tracked as "cycles used so far"; the phase ends when the used
    // count reaches its length (unheld cycles for the dwell).
    int              m_phase;
    int              m_used;
    int              m_sel;
    logic [RW-1:0]   m_row;
    logic            m_valid;
    logic [NP-1:0]   m_restart;
    logic [2:0]      m_colour;
    bit              m_live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_live    = 1'b1;
            m_phase   = 0;
            m_used    = 0;
            m_sel     = 0;
            m_row     = '0;
            m_valid   = 1'b0;
            m_restart = '0;
`ifdef COLOUR_CYCLE_EN
            m_colour  = 3'b001;
`else
            m_colour  = colour;
`endif
        end else if (m_live) begin
            if (m_phase != 0 && (!m_valid || ready)) begin
                m_row   = (m_phase == 1) ? rows[m_sel] : '0;
                m_valid = 1'b1;
            end
`ifndef COLOUR_CYCLE_EN
            m_colour = colour;
`endif
            m_restart = '0;
            if (m_phase == 0) begin
                m_phase   = 1;
                m_used    = 0;
                m_restart = 4'b0001;
            end else if (m_phase == 1) begin
                if (!hold) m_used++;
                if (next_p || m_used == DWELL) begin
                    m_phase = 2;
                    m_used  = 0;
                end
            end else begin
                m_used++;
                if (m_used == BLANK) begin
                    m_sel = (m_sel + 1) % NP;
`ifdef COLOUR_CYCLE_EN
                    if (m_sel == 0) m_colour = (m_colour == 3'd7) ? 3'd1 : m_colour + 3'd1;
`endif
                    m_restart = NP'(1) << m_sel;
                    m_phase   = 1;
                    m_used    = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("row_out",     64'(row_out),    64'(m_row));
            check("row_valid",   64'(row_valid),  64'(m_valid));
            check("pattern_sel", 64'(sel),        64'(m_sel));
            check("restart",     64'(restart),    64'(m_restart));
            check("colour_out",  64'(colour_out), 64'(m_colour));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1'b1;
        rows   = {ROW3, ROW2, ROW1, ROW0};
        colour = 3'b101;
        next_p = 1'b0;
        hold   = 1'b0;
        ready  = 1'b1;
        tick(3);
        reset = 1'b0;

        // Start-up: restart[0] first, then the first valid row.
        tick(1);
        check("lit_restart0", 64'(restart), 64'h1);
        check("lit_valid0",   64'(row_valid), 64'h0);
        tick(1);
        check("lit_first_valid", 64'(row_valid), 64'h1);
        check("lit_first_row",   64'(row_out), 64'(ROW0));

        // Free run: 64 shown rows, 16 blank rows, then pattern 1.
        tick(63);
        check("lit_last_row0", 64'(row_out), 64'(ROW0));
        check("lit_sel_hold0", 64'(sel), 64'h0);
        tick(1);
        check("lit_blank_row", 64'(row_out), 64'h0);
        tick(15);
        check("lit_sel1",      64'(sel), 64'h1);
        check("lit_restart1",  64'(restart), 64'h2);
        tick(1);
        check("lit_row1",      64'(row_out), 64'(ROW1));

        // next_in in the 10th RUN cycle.
        tick(9);
        next_p = 1'b1;
        tick(1);
        next_p = 1'b0;
        check("lit_next_last_row", 64'(row_out), 64'(ROW1));
        tick(1);
        check("lit_next_blank",    64'(row_out), 64'h0);
        tick(15);
        check("lit_sel2",          64'(sel), 64'h2);

        // next_in coinciding with dwell expiry: single advance.
        tick(63);
        next_p = 1'b1;
        tick(1);
        next_p = 1'b0;
        tick(16);
        check("lit_sel3_single", 64'(sel), 64'h3);

        // Stall across RUN->BLANK: the old row stays frozen, then drains.
        tick(57);
        ready   = 1'b0;
        rows[3] = ALT3;
        tick(20);
        check("lit_stall_row",   64'(row_out), 64'(ROW3));
        check("lit_stall_valid", 64'(row_valid), 64'h1);
        ready   = 1'b1;
        rows[3] = ROW3;
        tick(1);
        check("lit_drain_blank", 64'(row_out), 64'h0);
        tick(2);
        check("lit_wrap_sel0",   64'(sel), 64'h0);
        check("lit_wrap_rst0",   64'(restart), 64'h1);

        // Long hold: pattern never changes.
        tick(2);
        hold = 1'b1;
        tick(200);
        check("lit_hold_sel", 64'(sel), 64'h0);
        hold = 1'b0;

        // next_in honoured, then reset in the middle of a blank.
        next_p = 1'b1;
        tick(1);
        next_p = 1'b0;
        tick(20);
        check("lit_sel1_again", 64'(sel), 64'h1);
        next_p = 1'b1;
        tick(1);
        next_p = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(1);
        check("lit_rst_sel",   64'(sel), 64'h0);
        check("lit_rst_valid", 64'(row_valid), 64'h0);
        reset = 1'b0;

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1, 0) != 0) begin
                for (int p = 0; p < NP; p++) rows[p] = RW'($urandom);
            end
            ready  = ($urandom_range(3, 0) != 0);
            next_p = ($urandom_range(99, 0) == 0);
            if ($urandom_range(49, 0) == 0) hold = ~hold;
            if ($urandom_range(15, 0) == 0) colour = 3'($urandom);
            reset  = ($urandom_range(999, 0) == 0);
            tick(1);
        end
        reset = 1'b0;
        next_p = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
